// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I hazard/forwarding controller.
//   fwd_sel_e      : Execute-stage operand mux select encoding
//   RESULTSRC_LOAD : decode-stage ResultSrc value that marks a load
//   is_load()      : decodes a ResultSrc value into a load flag
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_SEL_M  = 2'b00,  // ALU result held in Memory stage
        FWD_SEL_W  = 2'b01,  // ResultW from Writeback stage
        FWD_SEL_RF = 2'b10   // register-file read data (RD1E/RD2E)
    } fwd_sel_e;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    function automatic logic is_load(input logic [1:0] result_src);
        return result_src == RESULTSRC_LOAD;
    endfunction

endpackage

// File: rtl/pipe_hazard_fwd_sel.sv
// Operand forwarding select for one Execute-stage source operand.
// Ports:
//   rs_i          : Execute-stage source register index
//   rd_m_i        : Memory-stage destination register index
//   reg_write_m_i : Memory-stage instruction writes rd
//   rd_w_i        : Writeback-stage destination register index
//   reg_write_w_i : Writeback-stage instruction writes rd
//   sel_o         : operand mux select (M beats W, otherwise register file)
module pipe_hazard_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic                  reg_write_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_w_i,
    output fwd_sel_e              sel_o
);

    // x0 reads as zero, so it is never a forwarding target.
    logic rs_nonzero;
    assign rs_nonzero = (rs_i != '0);

    always_comb begin
        // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
        sel_o = FWD_SEL_RF;
        // M is checked first: it holds the newer value when M and W both match.
        if (rs_nonzero && reg_write_m_i && (rs_i == rd_m_i)) begin
            sel_o = FWD_SEL_M;
        end else if (rs_nonzero && reg_write_w_i && (rs_i == rd_w_i)) begin
            sel_o = FWD_SEL_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline.
// Keeps shadow copies of the E/M/W destination-register state and derives the
// Execute-stage operand selects, load-use stalls and branch/jump flushes.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_rs1D/i_rs2D/i_rdD     : decode-stage register indices
//   i_RegWriteD             : decode-stage instruction writes rd
//   i_ResultSrcD            : decode-stage result source (load = RESULTSRC_LOAD)
//   i_PCSrcE                : Execute-stage branch taken or jump
//   o_ForwardAE/o_ForwardBE : SrcA / SrcB operand selects
//   o_StallF/o_StallD       : hold PC and IF/ID on a load-use hazard
//   o_FlushD/o_FlushE       : clear IF/ID and ID/EX
//   o_perf_stall/flush      : saturating stall/flush cycle counters
// Configuration: define PIPE_HAZARD_PERF_EN to build the perf counters;
// otherwise both perf ports are tied to zero.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_rs1D,
    input  logic [REG_ADDR_W-1:0] i_rs2D,
    input  logic [REG_ADDR_W-1:0] i_rdD,
    input  logic                  i_RegWriteD,
    input  logic [1:0]            i_ResultSrcD,
    input  logic                  i_PCSrcE,
    output logic [1:0]            o_ForwardAE,
    output logic [1:0]            o_ForwardBE,
    output logic                  o_StallF,
    output logic                  o_StallD,
    output logic                  o_FlushD,
    output logic                  o_FlushE,
    output logic [PERF_CNT_W-1:0] o_perf_stall,
    output logic [PERF_CNT_W-1:0] o_perf_flush
);

    // Shadow pipeline state
    logic [REG_ADDR_W-1:0] rs1e_q, rs2e_q, rde_q, rdm_q, rdw_q;
    logic                  reg_write_e_q, reg_write_m_q, reg_write_w_q;
    logic                  is_load_e_q;

    logic     lw_stall;
    fwd_sel_e fwd_a, fwd_b;

    // A load in E cannot forward to the dependent instruction in D yet.
    assign lw_stall = is_load_e_q && reg_write_e_q && (rde_q != '0) &&
                      ((i_rs1D == rde_q) || (i_rs2D == rde_q));

    assign o_StallF = lw_stall;
    assign o_StallD = lw_stall;
    assign o_FlushD = i_PCSrcE;
    assign o_FlushE = lw_stall | i_PCSrcE;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous; it drops any in-flight hazard on the next edge.
        if (i_rst || o_FlushE) begin
            // Bubble: a cleared RegWriteE means the slot never forwards or stalls.
            rs1e_q        <= '0;
            rs2e_q        <= '0;
            rde_q         <= '0;
            reg_write_e_q <= 1'b0;
            is_load_e_q   <= 1'b0;
        end else begin
            rs1e_q        <= i_rs1D;
            rs2e_q        <= i_rs2D;
            rde_q         <= i_rdD;
            reg_write_e_q <= i_RegWriteD;
            is_load_e_q   <= is_load(i_ResultSrcD);
        end

        if (i_rst) begin
            rdm_q         <= '0;
            reg_write_m_q <= 1'b0;
            rdw_q         <= '0;
            reg_write_w_q <= 1'b0;
        end else begin
            // No memory stalls: M and W always advance.
            rdm_q         <= rde_q;
            reg_write_m_q <= reg_write_e_q;
            rdw_q         <= rdm_q;
            reg_write_w_q <= reg_write_m_q;
        end
    end

    pipe_hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i          (rs1e_q),
        .rd_m_i        (rdm_q),
        .reg_write_m_i (reg_write_m_q),
        .rd_w_i        (rdw_q),
        .reg_write_w_i (reg_write_w_q),
        .sel_o         (fwd_a)
    );

    pipe_hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i          (rs2e_q),
        .rd_m_i        (rdm_q),
        .reg_write_m_i (reg_write_m_q),
        .rd_w_i        (rdw_q),
        .reg_write_w_i (reg_write_w_q),
        .sel_o         (fwd_b)
    );

    assign o_ForwardAE = fwd_a;
    assign o_ForwardBE = fwd_b;

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall_q, perf_flush_q;

    // Counters stop at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (lw_stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
            if (i_PCSrcE && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 1'b1;
            end
        end
    end

    assign o_perf_stall = perf_stall_q;
    assign o_perf_flush = perf_flush_q;
`else
    assign o_perf_stall = '0;
    assign o_perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (PERF_CNT_W = 4).
// Expected perf values depend on whether PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int PW = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rs1d, rs2d, rdd;
    logic          reg_write_d;
    logic [1:0]    result_src_d;
    logic          pcsrc_e;
    logic [1:0]    fwd_ae, fwd_be;
    logic          stall_f, stall_d, flush_d, flush_e;
    logic [PW-1:0] perf_stall, perf_flush;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .PERF_CNT_W(PW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rs1D       (rs1d),
        .i_rs2D       (rs2d),
        .i_rdD        (rdd),
        .i_RegWriteD  (reg_write_d),
        .i_ResultSrcD (result_src_d),
        .i_PCSrcE     (pcsrc_e),
        .o_ForwardAE  (fwd_ae),
        .o_ForwardBE  (fwd_be),
        .o_StallF     (stall_f),
        .o_StallD     (stall_d),
        .o_FlushD     (flush_d),
        .o_FlushE     (flush_e),
        .o_perf_stall (perf_stall),
        .o_perf_flush (perf_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a decode-stage instruction and let combinational outputs settle.
    task automatic set_d(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic rw,
                         input logic [1:0] rsrc, input logic pcs);
        rs1d = rs1; rs2d = rs2; rdd = rd;
        reg_write_d = rw; result_src_d = rsrc; pcsrc_e = pcs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        set_d(0, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_hazard(input string tag, input logic sf, input logic sd,
                                input logic fd, input logic fe);
        check({tag, ".StallF"}, 32'(stall_f), 32'(sf));
        check({tag, ".StallD"}, 32'(stall_d), 32'(sd));
        check({tag, ".FlushD"}, 32'(flush_d), 32'(fd));
        check({tag, ".FlushE"}, 32'(flush_e), 32'(fe));
    endtask

    logic [PW-1:0] exp_perf_stall, exp_perf_flush;

    initial begin
        rst = 1'b1;
        set_d(0, 0, 0, 0, 2'b00, 0);

        // 1: reset state, then one idle cycle after release
        tick(); tick();
        check("rst.FwdA", 32'(fwd_ae), 32'h2);
        check("rst.FwdB", 32'(fwd_be), 32'h2);
        check_hazard("rst", 0, 0, 0, 0);
        check("rst.perf_stall", 32'(perf_stall), 32'h0);
        check("rst.perf_flush", 32'(perf_flush), 32'h0);
        rst = 1'b0;
        tick();
        check("idle.FwdA", 32'(fwd_ae), 32'h2);
        check("idle.FwdB", 32'(fwd_be), 32'h2);
        check_hazard("idle", 0, 0, 0, 0);

        // 2a: add x5,x1,x2 ; sub x6,x5,x1 back-to-back -> forward from M
        set_d(1, 2, 5, 1, 2'b00, 0); tick();
        set_d(5, 1, 6, 1, 2'b00, 0);
        check("raw_m.nostall", 32'(stall_f), 32'h0);
        tick();
        check("raw_m.FwdA", 32'(fwd_ae), 32'h0);
        check("raw_m.FwdB", 32'(fwd_be), 32'h2);
        nops(4);

        // 2b: add x5 ; nop ; sub x6,x5,x1 -> forward from W
        set_d(1, 2, 5, 1, 2'b00, 0); tick();
        nops(1);
        set_d(5, 1, 6, 1, 2'b00, 0); tick();
        check("raw_w.FwdA", 32'(fwd_ae), 32'h1);
        check("raw_w.FwdB", 32'(fwd_be), 32'h2);
        nops(4);

        // 2c: add x5 ; add x5 ; use x5 in both operands -> M beats W
        set_d(1, 2, 5, 1, 2'b00, 0); tick();
        set_d(3, 4, 5, 1, 2'b00, 0); tick();
        set_d(5, 5, 9, 1, 2'b00, 0); tick();
        check("prio.FwdA", 32'(fwd_ae), 32'h0);
        check("prio.FwdB", 32'(fwd_be), 32'h0);
        nops(4);

        // 3: lw x7 ; add x8,x1,x7 -> one stall cycle, then forward from W
        set_d(1, 0, 7, 1, 2'b01, 0); tick();
        set_d(1, 7, 8, 1, 2'b00, 0);
        check_hazard("lu.stall", 1, 1, 0, 1);
        tick();
        check_hazard("lu.release", 0, 0, 0, 0);
        tick();
        check("lu.FwdB", 32'(fwd_be), 32'h1);
        check("lu.FwdA", 32'(fwd_ae), 32'h2);
`ifdef PIPE_HAZARD_PERF_EN
        exp_perf_stall = 4'd1;
`else
        exp_perf_stall = 4'd0;
`endif
        check("lu.perf_stall", 32'(perf_stall), 32'(exp_perf_stall));
        nops(4);

        // 4: writes to x0 never forward; lw x0 never stalls
        set_d(1, 2, 0, 1, 2'b00, 0); tick();
        set_d(0, 0, 9, 1, 2'b00, 0);
        check("x0.nostall", 32'(stall_f), 32'h0);
        tick();
        check("x0.FwdA", 32'(fwd_ae), 32'h2);
        check("x0.FwdB", 32'(fwd_be), 32'h2);
        nops(4);
        set_d(1, 0, 0, 1, 2'b01, 0); tick();
        set_d(0, 3, 10, 1, 2'b00, 0);
        check_hazard("lw_x0", 0, 0, 0, 0);
        tick();
        check("lw_x0.FwdA", 32'(fwd_ae), 32'h2);
        nops(4);

        // 5: branch taken coincident with load-use; bubble must not forward
        set_d(1, 0, 11, 1, 2'b01, 0); tick();
        set_d(11, 2, 12, 1, 2'b00, 1);
        check_hazard("br_lu", 1, 1, 1, 1);
        tick();
        set_d(12, 12, 13, 1, 2'b00, 0);
        check_hazard("br_lu.after", 0, 0, 0, 0);
        tick();
        check("bubble_m.FwdA", 32'(fwd_ae), 32'h2);
        check("bubble_m.FwdB", 32'(fwd_be), 32'h2);
        set_d(12, 0, 14, 1, 2'b00, 0); tick();
        check("bubble_w.FwdA", 32'(fwd_ae), 32'h2);
        nops(4);

        // 6: 20 more load-use stall cycles -> counter saturates at 4'hF
        for (int i = 0; i < 20; i++) begin
            set_d(1, 0, 7, 1, 2'b01, 0); tick();
            set_d(7, 0, 8, 1, 2'b00, 0);
            check($sformatf("sat.stall%0d", i), 32'(stall_f), 32'h1);
            tick();
        end
        nops(2);
`ifdef PIPE_HAZARD_PERF_EN
        exp_perf_stall = 4'hF;
        exp_perf_flush = 4'd1;
`else
        exp_perf_stall = 4'h0;
        exp_perf_flush = 4'd0;
`endif
        check("sat.perf_stall", 32'(perf_stall), 32'(exp_perf_stall));
        check("sat.perf_flush", 32'(perf_flush), 32'(exp_perf_flush));

        // Reset mid-operation: a pending load-use hazard vanishes
        set_d(1, 0, 7, 1, 2'b01, 0); tick();
        set_d(1, 7, 8, 1, 2'b00, 0);
        check("midrst.pre", 32'(stall_f), 32'h1);
        rst = 1'b1;
        tick();
        check_hazard("midrst", 0, 0, 0, 0);
        check("midrst.FwdA", 32'(fwd_ae), 32'h2);
        check("midrst.perf_stall", 32'(perf_stall), 32'h0);
        check("midrst.perf_flush", 32'(perf_flush), 32'h0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
